wb_arb: RTL and testbench

Parametrised multi-channel write-back stage. It accepts register-file write requests from NUM_CH independent producers, such as the ALU pipe, the load unit and the multi-cycle divider, through per-channel valid/ready handshakes. Each channel is buffered in its own small FIFO, and the channels are merged round-robin onto the single general-purpose register write port. It sits between the execute/memory producers and the register file, replacing the single-source pass-through write-back stage.

---
 rtl/wb_arb_pkg.sv | 27 ++
 rtl/wb_arb_fifo.sv | 69 ++++++
 rtl/wb_arb.sv | 138 +++++++++++++
 tb/tb_wb_arb.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared constants and helpers for the wb_arb write-back stage.
// Optional feature macro: WB_ARB_BYPASS_EN (same-cycle bypass of empty channel FIFOs).
package wb_arb_pkg;

  // Upper bound on the number of producer channels.
  localparam int WbChMax = 8;

  // Register-file bus widths for the default configuration.
  localparam int RegAddrBus = 5;
  localparam int RegBus     = 32;

  // Register-file write-enable encodings.
  typedef enum logic {
    WriteDisable = 1'b0,
    WriteEnable  = 1'b1
  } wr_en_e;

  // Round-robin successor: (k + 1) mod n.
  function automatic int unsigned rr_wrap_inc(input int unsigned k, input int unsigned n);
    if (k + 32'd1 >= n) begin
      return 32'd0;
    end else begin
      return k + 32'd1;
    end
  endfunction

endpackage

// File: rtl/wb_arb_fifo.sv
// wb_fifo: per-channel synchronous FIFO of DEPTH x W entries.
// Pointers are log2(DEPTH) bits and wrap naturally; the occupancy count is
// one bit wider so that full and empty can be told apart.
// Push while full and pop while empty are ignored.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 37
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] rdata
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [PW-1:0] wptr_r;
  logic [PW-1:0] rptr_r;
  logic [PW:0]   count_r;
  logic          do_push_s;
  logic          do_pop_s;

  // Status flags and head entry, all derived from registered state.
  always_comb begin
    full      = (count_r == (PW+1)'(DEPTH));
    empty     = (count_r == '0);
    rdata     = mem_r[rptr_r];
    do_push_s = push & ~full;
    do_pop_s  = pop & ~empty;
  end

  // Storage array: written at the write pointer on an accepted push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (do_push_s) begin
      mem_r[wptr_r] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (do_push_s) begin
        wptr_r <= wptr_r + PW'(1);
      end
      if (do_pop_s) begin
        rptr_r <= rptr_r + PW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (PW+1)'(1);
        2'b01:   count_r <= count_r - (PW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/wb_arb.sv
// wb_arb: multi-channel write-back stage. Each producer channel is buffered
// in its own wb_fifo; non-empty channels are merged round-robin onto the
// single register-file write port through registered outputs.
// Writes to x0 are accepted and dropped at the input.
// Optional feature macro: WB_ARB_BYPASS_EN -- an empty channel with a live
// request competes in the same cycle and, if granted, skips its FIFO.
module wb_arb
  import wb_arb_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int DEPTH  = 2,
  parameter int DW     = 32,
  parameter int AW     = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CH-1:0]    ch_valid_i,
  output logic [NUM_CH-1:0]    ch_ready_o,
  input  logic [NUM_CH*AW-1:0] ch_waddr_i,
  input  logic [NUM_CH*DW-1:0] ch_wdata_i,
  output logic                 reg_we_o,
  output logic [AW-1:0]        reg_waddr_o,
  output logic [DW-1:0]        reg_wdata_o,
  output logic                 wb_busy_o
);

  localparam int EW = AW + DW;
  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] full_s;
  logic [NUM_CH-1:0] empty_s;
  logic [NUM_CH-1:0] accept_s;
  logic [NUM_CH-1:0] live_s;
  logic [NUM_CH-1:0] bypass_s;
  logic [NUM_CH-1:0] cand_s;
  logic [NUM_CH-1:0] rot_s;
  logic [NUM_CH-1:0] grant_s;
  logic [NUM_CH-1:0] push_s;
  logic [NUM_CH-1:0] pop_s;
  logic [EW-1:0]     entry_s [NUM_CH];
  logic [EW-1:0]     head_s  [NUM_CH];
  logic [EW-1:0]     sel_s;
  logic [PW-1:0]     rr_ptr_r;
  logic [PW-1:0]     off_s;
  logic [PW:0]       sum_s;
  logic [PW-1:0]     gnt_idx_s;
  logic              gnt_any_s;

  // Ready and busy come straight from registered FIFO state.
  assign ch_ready_o = ~full_s;
  assign wb_busy_o  = |(~empty_s);

  // Per-channel FIFOs.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    wb_fifo #(
      .DEPTH (DEPTH),
      .W     (EW)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_s[g]),
      .pop   (pop_s[g]),
      .wdata (entry_s[g]),
      .full  (full_s[g]),
      .empty (empty_s[g]),
      .rdata (head_s[g])
    );
  end

  // Handshake qualification: an accepted request is live unless it targets x0.
  always_comb begin
    accept_s = '0;
    live_s   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      entry_s[i]  = {ch_waddr_i[i*AW +: AW], ch_wdata_i[i*DW +: DW]};
      accept_s[i] = ch_valid_i[i] & ~full_s[i];
      live_s[i]   = accept_s[i] & (ch_waddr_i[i*AW +: AW] != '0);
    end
`ifdef WB_ARB_BYPASS_EN
    bypass_s = live_s & empty_s;
`else
    bypass_s = '0;
`endif
    cand_s = ~empty_s | bypass_s;
  end

  // Round-robin search: rotate candidates so rr_ptr is bit 0, take the lowest set bit.
  always_comb begin
    rot_s     = NUM_CH'({cand_s, cand_s} >> rr_ptr_r);
    gnt_any_s = |rot_s;
    off_s     = '0;
    for (int j = NUM_CH - 1; j >= 0; j--) begin
      off_s = rot_s[j] ? PW'(j) : off_s;
    end
    sum_s = {1'b0, rr_ptr_r} + {1'b0, off_s};
    if (sum_s >= (PW+1)'(NUM_CH)) begin
      gnt_idx_s = PW'(sum_s - (PW+1)'(NUM_CH));
    end else begin
      gnt_idx_s = sum_s[PW-1:0];
    end
  end

  // Grant decode, FIFO push/pop steering and output data selection.
  always_comb begin
    grant_s = '0;
    pop_s   = '0;
    push_s  = '0;
    sel_s   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      grant_s[i] = gnt_any_s & (gnt_idx_s == PW'(i));
      pop_s[i]   = grant_s[i] & ~empty_s[i];
      // A granted empty channel can only be a bypass win, so it is not enqueued.
      push_s[i]  = live_s[i] & ~(grant_s[i] & empty_s[i]);
      sel_s      = grant_s[i] ? (empty_s[i] ? entry_s[i] : head_s[i]) : sel_s;
    end
  end

  // Output registers and round-robin pointer; address/data hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_we_o    <= WriteDisable;
      reg_waddr_o <= '0;
      reg_wdata_o <= '0;
      rr_ptr_r    <= '0;
    end else if (gnt_any_s) begin
      reg_we_o    <= WriteEnable;
      reg_waddr_o <= sel_s[EW-1:DW];
      reg_wdata_o <= sel_s[DW-1:0];
      rr_ptr_r    <= PW'(rr_wrap_inc(32'(gnt_idx_s), NUM_CH));
    end else begin
      reg_we_o    <= WriteDisable;
      reg_waddr_o <= reg_waddr_o;
      reg_wdata_o <= reg_wdata_o;
      rr_ptr_r    <= rr_ptr_r;
    end
  end

endmodule

// File: tb/tb_wb_arb.sv
// Directed testbench for wb_arb (default 3 channels, depth 2).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_wb_arb;

  localparam int NUM_CH = 3;
  localparam int DEPTH  = 2;
  localparam int DW     = 32;
  localparam int AW     = 5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_CH-1:0]    ch_valid;
  logic [NUM_CH-1:0]    ch_ready;
  logic [NUM_CH*AW-1:0] ch_waddr;
  logic [NUM_CH*DW-1:0] ch_wdata;
  logic                 reg_we;
  logic [AW-1:0]        reg_waddr;
  logic [DW-1:0]        reg_wdata;
  logic                 wb_busy;

  int tests_run    = 0;
  int tests_failed = 0;

  wb_arb #(
    .NUM_CH (NUM_CH),
    .DEPTH  (DEPTH),
    .DW     (DW),
    .AW     (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ch_valid_i  (ch_valid),
    .ch_ready_o  (ch_ready),
    .ch_waddr_i  (ch_waddr),
    .ch_wdata_i  (ch_wdata),
    .reg_we_o    (reg_we),
    .reg_waddr_o (reg_waddr),
    .reg_wdata_o (reg_wdata),
    .wb_busy_o   (wb_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_ch(input int ch, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ch_valid[ch]           = v;
    ch_waddr[ch*AW +: AW]  = a;
    ch_wdata[ch*DW +: DW]  = d;
  endtask

  task automatic clear_all();
    ch_valid = '0;
    ch_waddr = '0;
    ch_wdata = '0;
  endtask

  task automatic do_reset();
    clear_all();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (wb_busy && n < 50) begin
      step();
      n++;
    end
    step();
    check(tag, {63'd0, wb_busy}, 64'd0);
  endtask

  int idx;
  int got_n;
  logic acc_prev;

  initial begin
    rst = 1'b1;
    clear_all();
    repeat (2) step();

    // Reset state
    check("rst_we",    {63'd0, reg_we}, 64'd0);
    check("rst_waddr", {59'd0, reg_waddr}, 64'd0);
    check("rst_wdata", {32'd0, reg_wdata}, 64'd0);
    check("rst_busy",  {63'd0, wb_busy}, 64'd0);
    check("rst_ready", {61'd0, ch_ready}, 64'h7);
    rst = 1'b0;
    step();

    // Single channel: ch0 writes x5 = 0xDEADBEEF
    set_ch(0, 1'b1, 5'd5, 32'hDEADBEEF);
    step();
    set_ch(0, 1'b0, 5'd0, 32'd0);
`ifndef WB_ARB_BYPASS_EN
    check("single_lat_we0", {63'd0, reg_we}, 64'd0);
    check("single_lat_busy", {63'd0, wb_busy}, 64'd1);
    step();
`endif
    check("single_we",    {63'd0, reg_we}, 64'd1);
    check("single_waddr", {59'd0, reg_waddr}, 64'd5);
    check("single_wdata", {32'd0, reg_wdata}, 64'hDEADBEEF);
    step();
    check("single_we_off",    {63'd0, reg_we}, 64'd0);
    check("single_waddr_hold", {59'd0, reg_waddr}, 64'd5);
    check("single_wdata_hold", {32'd0, reg_wdata}, 64'hDEADBEEF);

    // Reset mid-stream with two requests in flight
    set_ch(0, 1'b1, 5'd7, 32'h77);
    set_ch(1, 1'b1, 5'd8, 32'h88);
    step();
    clear_all();
    check("midrst_busy_pre", {63'd0, wb_busy}, 64'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst_we",    {63'd0, reg_we}, 64'd0);
    check("midrst_waddr", {59'd0, reg_waddr}, 64'd0);
    check("midrst_wdata", {32'd0, reg_wdata}, 64'd0);
    check("midrst_busy",  {63'd0, wb_busy}, 64'd0);
    check("midrst_ready", {61'd0, ch_ready}, 64'h7);
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("midrst_no_write", {63'd0, reg_we}, 64'd0);
      check("midrst_idle", {63'd0, wb_busy}, 64'd0);
    end

    // Fairness: all channels valid continuously, expect 0,1,2,0,1,2
    for (int i = 0; i < NUM_CH; i++) begin
      set_ch(i, 1'b1, 5'(i + 1), 32'h100 + 32'(i));
    end
    step();
`ifndef WB_ARB_BYPASS_EN
    check("fair_first_idle", {63'd0, reg_we}, 64'd0);
    step();
`endif
    for (int k = 0; k < 6; k++) begin
      check("fair_we",    {63'd0, reg_we}, 64'd1);
      check("fair_waddr", {59'd0, reg_waddr}, 64'((k % 3) + 1));
      check("fair_wdata", {32'd0, reg_wdata}, 64'h100 + 64'(k % 3));
      step();
    end
    clear_all();
    wait_idle("fair_drain");

    // Full: ch1 sends 3 requests against continuous ch0/ch2 traffic
    do_reset();
    set_ch(0, 1'b1, 5'd1, 32'h100);
    set_ch(2, 1'b1, 5'd3, 32'h300);
    idx      = 0;
    got_n    = 0;
    acc_prev = 1'b0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (acc_prev) begin
        idx++;
      end
      if (reg_we && reg_waddr >= 5'd10 && reg_waddr <= 5'd12) begin
        check("full_order_addr", {59'd0, reg_waddr}, 64'(10 + got_n));
        check("full_order_data", {32'd0, reg_wdata}, 64'hA0 + 64'(got_n));
        got_n++;
      end
`ifndef WB_ARB_BYPASS_EN
      if (cyc == 2) begin
        check("full_ready_low", {63'd0, ch_ready[1]}, 64'd0);
        check("full_two_acc",   64'(idx), 64'd2);
      end
      if (cyc == 3) begin
        check("full_ready_back", {63'd0, ch_ready[1]}, 64'd1);
        check("full_third_held", 64'(idx), 64'd2);
      end
`endif
      if (idx < 3) begin
        set_ch(1, 1'b1, 5'(10 + idx), 32'hA0 + 32'(idx));
      end else begin
        set_ch(1, 1'b0, 5'd0, 32'd0);
      end
      acc_prev = ch_valid[1] && ch_ready[1];
      step();
    end
    clear_all();
    wait_idle("full_drain");
    check("full_count", 64'(got_n), 64'd3);

    // x0 drop: accepted, never written, never pending
    do_reset();
    set_ch(2, 1'b1, 5'd0, 32'h1234);
    check("x0_ready", {63'd0, ch_ready[2]}, 64'd1);
    step();
    clear_all();
    for (int k = 0; k < 4; k++) begin
      check("x0_no_write", {63'd0, reg_we}, 64'd0);
      check("x0_not_busy", {63'd0, wb_busy}, 64'd0);
      step();
    end

`ifdef WB_ARB_BYPASS_EN
    // Bypass corner: rr_ptr = 1, ch0 and ch1 both empty and valid
    do_reset();
    set_ch(0, 1'b1, 5'd9, 32'h99);
    step();
    clear_all();
    check("byp_setup_we", {63'd0, reg_we}, 64'd1);
    step();
    set_ch(0, 1'b1, 5'd20, 32'h2000);
    set_ch(1, 1'b1, 5'd21, 32'h2100);
    step();
    clear_all();
    check("byp_n1_we",    {63'd0, reg_we}, 64'd1);
    check("byp_n1_waddr", {59'd0, reg_waddr}, 64'd21);
    check("byp_n1_wdata", {32'd0, reg_wdata}, 64'h2100);
    step();
    check("byp_n2_we",    {63'd0, reg_we}, 64'd1);
    check("byp_n2_waddr", {59'd0, reg_waddr}, 64'd20);
    check("byp_n2_wdata", {32'd0, reg_wdata}, 64'h2000);
    step();
    check("byp_idle", {63'd0, reg_we}, 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
